// File: rtl/helen_mem_master_if.sv
`default_nettype none
// ============================================================================
// Interface : helen_mem_master_if
// Brief     : Command handshake, status and memory bus of helen_mem_master.
// Revision  : 1.0 - initial release
// ============================================================================
interface helen_mem_master_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_seed;

    logic [ADDR_W-1:0] address;
    logic [1:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    logic              busy;
    logic              done;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] first_err_addr;

    modport master (
        input  cmd_valid, cmd_op, cmd_base, cmd_len, cmd_seed, readdata,
        output cmd_ready, address, byteenable, chipselect, write, writedata,
               busy, done, err_count, first_err_addr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_base, cmd_len, cmd_seed, readdata,
        input  cmd_ready, address, byteenable, chipselect, write, writedata,
               busy, done, err_count, first_err_addr
    );
endinterface
`default_nettype wire

// File: rtl/helen_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : helen_mem_master
// Brief    : Fills a memory window with an incrementing pattern or checks it,
//            counting mismatches and recording the first failing address.
// Revision : 1.0 - initial release
// ============================================================================
module helen_mem_master #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    helen_mem_master_if.master bus
);
    localparam logic [ADDR_W:0] c_LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_pat;
    logic [ADDR_W:0]   r_remain;
    logic              r_cmp_valid;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic [DATA_W-1:0] r_cmp_exp;
    logic [ADDR_W:0]   r_err_count;
    logic [ADDR_W-1:0] r_first_err;

    logic [ADDR_W:0]   w_len_clamped;
    logic              w_last;
    logic              w_accept;
    logic              w_cmd_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_chipselect;
    logic              w_write;
    logic              w_mismatch;

    assign w_len_clamped = (bus.cmd_len > c_LEN_MAX) ? c_LEN_MAX : bus.cmd_len;
    assign w_last        = (r_remain == (ADDR_W+1)'(1));
    assign w_mismatch    = r_cmp_valid && (bus.readdata != r_cmp_exp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cmd_ready  = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_chipselect = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_busy   = 1'b1;
                    if (w_len_clamped == '0) begin
                        w_state_next = S_DONE;
                    end else if (bus.cmd_op) begin
                        w_state_next = S_READ;
                    end else begin
                        w_state_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                w_busy       = 1'b1;
                w_chipselect = 1'b1;
                w_write      = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_READ: begin
                w_busy       = 1'b1;
                w_chipselect = 1'b1;
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy       = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Reset silences every strobe combinationally so an abort emits nothing.
        if (reset) begin
            w_accept     = 1'b0;
            w_cmd_ready  = 1'b0;
            w_busy       = 1'b0;
            w_done       = 1'b0;
            w_chipselect = 1'b0;
            w_write      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_pat       <= '0;
            r_remain    <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_exp   <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else begin
            r_cmp_valid <= 1'b0;
            if (w_accept) begin
                r_addr      <= bus.cmd_base;
                r_pat       <= bus.cmd_seed;
                r_remain    <= w_len_clamped;
                r_err_count <= '0;
                r_first_err <= '0;
            end else if (w_chipselect) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_pat    <= r_pat + DATA_W'(1);
                r_remain <= r_remain - (ADDR_W+1)'(1);
            end
            // Read data returns one cycle later, so carry address and expectation.
            if (w_chipselect && !w_write) begin
                r_cmp_valid <= 1'b1;
                r_cmp_addr  <= r_addr;
                r_cmp_exp   <= r_pat;
            end
            if (w_mismatch) begin
                r_err_count <= r_err_count + (ADDR_W+1)'(1);
                if (r_err_count == '0) begin
                    r_first_err <= r_cmp_addr;
                end
            end
        end
    end

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.busy           = w_busy;
    assign bus.done           = w_done;
    assign bus.chipselect     = w_chipselect;
    assign bus.write          = w_write;
    assign bus.byteenable     = 2'b11;
    assign bus.address        = reset ? '0 : r_addr;
    assign bus.writedata      = reset ? '0 : r_pat;
    assign bus.err_count      = reset ? '0 : r_err_count;
    assign bus.first_err_addr = reset ? '0 : r_first_err;

endmodule
`default_nettype wire

// File: doc/helen_mem_master.md
HELEN_MEM_MASTER -- requirements
Module: helen_mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width (two byte lanes).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have port cmd_op  input  1  operation: 0 = fill, 1 = check.
REQ-008 SHALL have port cmd_base  input  ADDR_W  first word address.
REQ-009 SHALL have port cmd_len  input  ADDR_W+1  word count, 0..2^ADDR_W.
REQ-010 SHALL have port cmd_seed  input  DATA_W  pattern seed.
REQ-011 SHALL have port address  output  ADDR_W  memory word address.
REQ-012 SHALL have port byteenable  output  2  byte lanes, held at 2'b11.
REQ-013 SHALL have port chipselect  output  1  memory access strobe.
REQ-014 SHALL have port write  output  1  write qualifier; chipselect & ~write is a read.
REQ-015 SHALL have port writedata  output  DATA_W  write data.
REQ-016 SHALL have port readdata  input  DATA_W  read data, valid exactly 1 cycle after the read strobe.
REQ-017 SHALL have port busy  output  1  high from the accept cycle until done.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port err_count  output  ADDR_W+1  mismatch count of the last check.
REQ-020 SHALL have port first_err_addr  output  ADDR_W  address of the first mismatch of the last check.

Function
REQ-021 SHALL implement states IDLE, FILL, READ, DRAIN, DONE; cmd_ready = 1 only in IDLE.
REQ-022 On accept: latch op/base/len/seed, clear index, err_count and first_err_addr; go to FILL (op=0) or READ (op=1); len=0 goes directly to DONE.
REQ-023 Word i SHALL use address = (base + i) mod 2^ADDR_W (wrap-around) and pattern P(i) = (seed + i) mod 2^DATA_W.
REQ-024 FILL: one write per cycle, chipselect=1, write=1, writedata=P(i), no gaps; after word len-1 go to DONE.
REQ-025 READ: one read per cycle, chipselect=1, write=0; after issuing word len-1 go to DRAIN.
REQ-026 Compare pipeline: readdata in cycle t+1 SHALL be compared against P(i) of the read issued in cycle t; the address and expected value are carried one stage.
REQ-027 On mismatch: err_count increments by 1; first_err_addr loads only if err_count was 0.
REQ-028 DRAIN: one cycle for the final compare, then DONE.
REQ-029 DONE: done=1 for exactly one cycle, busy drops in the same cycle, next state IDLE.
REQ-030 Outside FILL/READ: chipselect=0, write=0; writedata and address are don't-care but stable.
REQ-031 A fill SHALL complete in len+2 cycles (accept to done inclusive); a check in len+3 cycles.
REQ-032 err_count and first_err_addr SHALL hold their values until the next accepted command; a fill leaves them 0.
REQ-033 cmd_len values > 2^ADDR_W SHALL be clamped to 2^ADDR_W.

Reset
REQ-034 While reset=1: state IDLE, cmd_ready=0, chipselect=0, write=0, busy=0, done=0, err_count=0, first_err_addr=0, address=0, writedata=0, byteenable=2'b11.
REQ-035 Reset asserted mid-operation SHALL abort the operation in the same edge; no strobe is issued in the following cycle and no done pulse is produced.
REQ-036 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-037 Fill base=0x0010, len=4, seed=0xFFFE -> writes 0x0010..0x0013 with data FFFE, FFFF, 0000, 0001 on consecutive cycles; done 6 cycles after accept.
REQ-038 Fill base=0x3FFE, len=3, seed=0x1234, then check with the same parameters -> addresses 3FFE, 3FFF, 0000; err_count=0; check done 6 cycles after its accept.
REQ-039 Check with a memory model corrupted at 0x0005 and 0x0007, base=0, len=8 -> err_count=2, first_err_addr=0x0005.
REQ-040 cmd_len=0 -> no chipselect; done 2 cycles after accept; err_count=0.
REQ-041 Reset asserted in the 3rd cycle of a 10-word fill -> exactly 2 writes observed, no done pulse, cmd_ready=1 in the first cycle after reset deasserts.
REQ-042 cmd_valid held high continuously -> each next command is accepted only in IDLE, one cycle after the previous done pulse.
